// File: rtl/fp_operand_sweeper_if.sv
// rtl/fp_operand_sweeper_if.sv - control and operand-stream bundle for fp_operand_sweeper
interface fp_operand_sweeper_if #(
  parameter int W = 32
);
  logic          start;
  logic [1:0]    mode;
  logic [31:0]   seed_x1;
  logic [31:0]   seed_x2;
  logic          out_ready;
  logic [W-1:0]  x1;
  logic [W-1:0]  x2;
  logic          val;
  logic          last;
  logic          busy;
  logic          done;
  logic [31:0]   vec_cnt;

  // Generator side: takes run control and back-pressure, drives the operand stream.
  modport master (
    input  start, mode, seed_x1, seed_x2, out_ready,
    output x1, x2, val, last, busy, done, vec_cnt
  );

  // Consumer side: issues run control and back-pressure, receives the operand stream.
  modport slave (
    output start, mode, seed_x1, seed_x2, out_ready,
    input  x1, x2, val, last, busy, done, vec_cnt
  );
endinterface

// File: rtl/fp_operand_sweeper.sv
// rtl/fp_operand_sweeper.sv - floating-point operand-pair stimulus generator
module fp_operand_sweeper #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 23,
  parameter int RAND_COUNT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_operand_sweeper_if.master   bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [1:0] M_DIR   = 2'd0;
  localparam logic [1:0] M_WALK  = 2'd1;
  localparam logic [1:0] M_COUNT = 2'd2;
  localparam logic [1:0] M_RAND  = 2'd3;

  // Largest finite exponent (EMAX-1); EMAX itself is reserved for Inf/NaN.
  localparam logic [EXP_W-1:0] EXP_LAST = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] E_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [MAN_W-1:0] M_ONE    = {{(MAN_W-1){1'b0}}, 1'b1};
  // Both sweep modes end on the largest-magnitude negative finite value.
  localparam logic [W-1:0]     OP_FINAL = {1'b1, EXP_LAST, {MAN_W{1'b1}}};
  localparam logic [31:0]      LFSR_TAP = 32'h8020_0003;
  localparam logic [31:0]      RAND_LAST = 32'(RAND_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_n;
  logic [1:0]    mode_q, mode_n;
  logic [W-1:0]  x1_q, x1_n, x2_q, x2_n;
  logic [31:0]   lfsr1_q, lfsr1_n, lfsr2_q, lfsr2_n;
  logic [31:0]   rcnt_q, rcnt_n;
  logic [31:0]   cnt_q, cnt_n;
  logic          val_q, val_n, last_q, last_n;
  logic          busy_q, busy_n, done_q, done_n;

  logic          xfer;
  logic          walk;
  logic [W:0]    adv1, adv2;
  logic [31:0]   step1, step2;
  logic [31:0]   seed1, seed2;
  logic [31:0]   rcnt_inc;

  // Right-shifting Galois LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAP) : (s >> 1);
  endfunction

  // Next operand in a sweep; bit W flags the wrap back to +0 so the outer operand can advance.
  function automatic logic [W:0] advance(input logic [W-1:0] op, input logic walk_mode);
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             wrap;
    s    = op[W-1];
    e    = op[W-2:MAN_W];
    m    = op[MAN_W-1:0];
    wrap = 1'b0;
    if (&m) begin
      m = '0;
      if (e == EXP_LAST) begin
        // Positive half done -> restart at -0; negative half done -> back to +0.
        e    = '0;
        wrap = s;
        s    = ~s;
      end else begin
        e = e + E_ONE;
      end
    end else if (walk_mode) begin
      m = {m[MAN_W-2:0], 1'b1};
    end else begin
      m = m + M_ONE;
    end
    return {wrap, s, e, m};
  endfunction

  assign xfer     = val_q & bus.out_ready;
  assign walk     = (mode_q == M_WALK);
  assign adv1     = advance(x1_q, walk);
  assign adv2     = advance(x2_q, walk);
  assign step1    = lfsr_step(lfsr1_q);
  assign step2    = lfsr_step(lfsr2_q);
  assign seed1    = (bus.seed_x1 == 32'd0) ? 32'd1 : bus.seed_x1;
  assign seed2    = (bus.seed_x2 == 32'd0) ? 32'd1 : bus.seed_x2;
  assign rcnt_inc = rcnt_q + 32'd1;

  // Next-state and next-output logic: run launch, per-transfer advance and completion.
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    x1_n    = x1_q;
    x2_n    = x2_q;
    lfsr1_n = lfsr1_q;
    lfsr2_n = lfsr2_q;
    rcnt_n  = rcnt_q;
    cnt_n   = cnt_q;
    val_n   = val_q;
    last_n  = last_q;
    busy_n  = busy_q;
    done_n  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = RUN;
          mode_n  = bus.mode;
          val_n   = 1'b1;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          cnt_n   = '0;
          rcnt_n  = 32'd1;
          case (bus.mode)
            M_DIR: begin
              x1_n   = bus.seed_x1[W-1:0];
              x2_n   = bus.seed_x2[W-1:0];
              last_n = 1'b1;
            end
            M_WALK, M_COUNT: begin
              x1_n   = '0;
              x2_n   = '0;
              last_n = 1'b0;
            end
            default: begin
              lfsr1_n = seed1;
              lfsr2_n = seed2;
              x1_n    = seed1[W-1:0];
              x2_n    = seed2[W-1:0];
              last_n  = (RAND_LAST == 32'd1);
            end
          endcase
        end
      end
      RUN: begin
        if (xfer) begin
          if (cnt_q != 32'hFFFF_FFFF) cnt_n = cnt_q + 32'd1;
          if (last_q) begin
            state_n = DONE;
            val_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            last_n  = 1'b0;
          end else begin
            case (mode_q)
              M_RAND: begin
                lfsr1_n = step1;
                lfsr2_n = step2;
                x1_n    = step1[W-1:0];
                x2_n    = step2[W-1:0];
                rcnt_n  = rcnt_inc;
                last_n  = (rcnt_inc == RAND_LAST);
              end
              M_WALK, M_COUNT: begin
                x1_n   = adv1[W-1:0];
                if (adv1[W]) x2_n = adv2[W-1:0];
                last_n = (adv1[W-1:0] == OP_FINAL) &&
                         ((adv1[W] ? adv2[W-1:0] : x2_q) == OP_FINAL);
              end
              default: ;
            endcase
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; asynchronous reset returns everything to idle zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= M_DIR;
      x1_q    <= '0;
      x2_q    <= '0;
      lfsr1_q <= 32'd1;
      lfsr2_q <= 32'd1;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      x1_q    <= x1_n;
      x2_q    <= x2_n;
      lfsr1_q <= lfsr1_n;
      lfsr2_q <= lfsr2_n;
      rcnt_q  <= rcnt_n;
      cnt_q   <= cnt_n;
      val_q   <= val_n;
      last_q  <= last_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.x1      = x1_q;
  assign bus.x2      = x2_q;
  assign bus.val     = val_q;
  assign bus.last    = last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.vec_cnt = cnt_q;
endmodule
